// File: rtl/alu_traffic_gen.sv
// Operand initiator / result checker for the ALU valid-ready adder stage.
// Optional result-side backpressure is enabled by defining ALU_TGEN_BP_EN.
module alu_traffic_gen #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               i_CLK,
  input  logic               i_RSTn,
  input  logic               i_START,
  input  logic [CNT_W-1:0]   i_NUM,
  output logic [WIDTH-1:0]   o_A,
  output logic [WIDTH-1:0]   o_B,
  output logic               o_VALID,
  input  logic               i_READY,
  input  logic [WIDTH-1:0]   i_Y,
  input  logic               i_VALID,
  output logic               o_READY,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic               o_ERR,
  output logic [CNT_W-1:0]   o_ERR_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     num_reg, num_next;
  logic [CNT_W-1:0]     issue_reg, issue_next;
  logic [CNT_W-1:0]     recv_reg, recv_next;
  logic                 valid_reg, valid_next;
  logic [WIDTH-1:0]     a_reg, a_next, b_reg, b_next;
  logic                 err_reg, err_next;
  logic [CNT_W-1:0]     err_cnt_reg, err_cnt_next;
  logic [AW-1:0]        wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     fifo_head;
  logic [2*WIDTH-1:0]   pair_idx;
  logic                 push, pop, op_hs, res_hs, busy, rdy_gate;

`ifdef ALU_TGEN_BP_EN
  logic [7:0] lfsr_reg;
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) lfsr_reg <= 8'hA5;
    else         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end
  assign rdy_gate = lfsr_reg[0];
`else
  assign rdy_gate = 1'b1;
`endif

  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign fifo_head = mem[rd_ptr_reg];
  assign op_hs     = valid_reg & i_READY;
  assign res_hs    = i_VALID & o_READY;

  assign o_A       = a_reg;
  assign o_B       = b_reg;
  assign o_VALID   = valid_reg;
  assign o_READY   = busy & (count_reg != '0) & rdy_gate;
  assign o_BUSY    = busy;
  assign o_DONE    = (state_reg == DONE);
  assign o_ERR     = err_reg;
  assign o_ERR_CNT = err_cnt_reg;

  always_comb begin
    state_next   = state_reg;
    num_next     = num_reg;
    issue_next   = issue_reg;
    recv_next    = recv_reg;
    valid_next   = valid_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    err_next     = err_reg;
    err_cnt_next = err_cnt_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    push         = 1'b0;
    pop          = 1'b0;
    pair_idx     = '0;
    unique case (state_reg)
      IDLE, DONE: begin
        if (i_START) begin
          num_next     = i_NUM;
          issue_next   = '0;
          recv_next    = '0;
          valid_next   = 1'b0;
          a_next       = '0;
          b_next       = '0;
          err_next     = 1'b0;
          err_cnt_next = '0;
          wr_ptr_next  = '0;
          rd_ptr_next  = '0;
          count_next   = '0;
          state_next   = (i_NUM == '0) ? DONE : RUN;
        end
      end
      RUN, DRAIN: begin
        if (op_hs) begin
          push        = 1'b1;
          issue_next  = issue_reg + CNT_W'(1);
          wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (res_hs) begin
          pop         = 1'b1;
          recv_next   = recv_reg + CNT_W'(1);
          rd_ptr_next = rd_ptr_reg + AW'(1);
          if (fifo_head != i_Y) begin
            err_next = 1'b1;
            if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + CNT_W'(1);
          end
        end
        count_next = count_reg + CW'(push) - CW'(pop);
        pair_idx   = (2*WIDTH)'(issue_next);
        if (state_reg == RUN) begin
          if (op_hs && (issue_reg == num_reg - CNT_W'(1))) begin
            valid_next = 1'b0;
            state_next = DRAIN;
          end else if ((!valid_reg || op_hs) && (count_next < CW'(DEPTH))) begin
            // Present the next pair only if its result will have a FIFO slot.
            valid_next = 1'b1;
            a_next     = pair_idx[WIDTH-1:0];
            b_next     = pair_idx[2*WIDTH-1:WIDTH];
          end else if (op_hs) begin
            valid_next = 1'b0;
          end
        end else if (res_hs && (recv_reg == num_reg - CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      num_reg     <= '0;
      issue_reg   <= '0;
      recv_reg    <= '0;
      valid_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      num_reg     <= num_next;
      issue_reg   <= issue_next;
      recv_reg    <= recv_next;
      valid_reg   <= valid_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
    end
  end

  // Expected sums; contents need no reset since count gates every read.
  always_ff @(posedge i_CLK) begin
    if (push) mem[wr_ptr_reg] <= a_reg + b_reg;
  end
endmodule

// File: tb/tb_alu_traffic_gen.sv
// Bench for alu_traffic_gen: models a 1-cycle adder stage and scoreboards the operand sweep.
module tb_alu_traffic_gen;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num;
  logic [W-1:0]  a, b, y;
  logic          op_valid, op_ready, res_valid, res_ready;
  logic          busy, done, err;
  logic [CW-1:0] err_cnt;

  alu_traffic_gen #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_START(start), .i_NUM(num),
    .o_A(a), .o_B(b), .o_VALID(op_valid), .i_READY(op_ready),
    .i_Y(y), .i_VALID(res_valid), .o_READY(res_ready),
    .o_BUSY(busy), .o_DONE(done), .o_ERR(err), .o_ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]   exp_pair_q[$];
  logic [W-1:0] stage_q[$];
  int  issued, returned, model_err, corrupt_idx, stall_left;
  bit  hold_res, rnd_ready, stall_armed, pend;
  logic [W-1:0] pend_a, pend_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {a, b, op_valid, res_ready, busy, done, err, err_cnt}, 32'd0);
  endtask

  // One clock: decide handshakes at negedge, update stage model, drive its outputs after posedge.
  task automatic cycle();
    bit res_hs, op_hs;
    logic [7:0]   e;
    logic [W-1:0] s;
    @(negedge clk);
    res_hs = res_valid && res_ready;
    if (stall_armed && op_valid && a == 4'd2 && b == 4'd0) begin
      stall_left  = 5;
      stall_armed = 1'b0;
    end
    if (stall_left > 0) begin
      op_ready = 1'b0;
      stall_left--;
    end else begin
      op_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (pend) begin
      check("hold_valid", op_valid, 1'b1);
      check("hold_a", a, pend_a);
      check("hold_b", b, pend_b);
    end
    op_hs  = op_valid && op_ready;
    pend   = op_valid && !op_ready;
    pend_a = a;
    pend_b = b;
    if (res_hs) begin
      void'(stage_q.pop_front());
      returned++;
    end
    if (op_hs) begin
      if (exp_pair_q.size() == 0) begin
        check("extra_op", exp_pair_q.size(), 1);
      end else begin
        e = exp_pair_q.pop_front();
        check("op_a", a, e[3:0]);
        check("op_b", b, e[7:4]);
      end
      s = a + b;
      if (issued == corrupt_idx) begin
        if (s != 4'd0) model_err++;
        s = 4'd0;
      end
      stage_q.push_back(s);
      $display("op #%0d a=%0d b=%0d y=%0d", issued, a, b, s);
      issued++;
    end
    @(posedge clk);
    #1;
    res_valid = (stage_q.size() > 0) && !hold_res;
    y         = (stage_q.size() > 0) ? stage_q[0] : '0;
  endtask

  task automatic start_run(input int n);
    exp_pair_q.delete();
    stage_q.delete();
    issued = 0; returned = 0; model_err = 0; pend = 1'b0;
    for (int k = 0; k < n; k++) exp_pair_q.push_back(8'(k));
    @(negedge clk);
    res_valid = 1'b0;
    start     = 1'b1;
    num       = CW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      cycle();
      c++;
    end
    check("done", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("issued", issued, n);
    check("returned", returned, n);
    check("pairs_left", exp_pair_q.size(), 0);
    check("err", err, model_err != 0);
    check("err_cnt", err_cnt, model_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num = '0; op_ready = 1'b0;
    res_valid = 1'b0; y = '0;
    hold_res = 1'b0; rnd_ready = 1'b0; stall_armed = 1'b0; stall_left = 0;
    corrupt_idx = -1; pend = 1'b0;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); num = CW'($urandom); op_ready = 1'($urandom);
      res_valid = 1'($urandom); y = W'($urandom);
      #1 check_all_zero("in_reset");
    end
    @(negedge clk);
    start = 1'b0; num = '0; op_ready = 1'b0; res_valid = 1'b0; y = '0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_all_zero("idle_after_reset");

    // Basic run of three
    start_run(3);
    check("busy_run", busy, 1'b1);
    wait_done(3, 50);

    // Operand backpressure on pair (2,0)
    stall_armed = 1'b1;
    start_run(5);
    wait_done(5, 80);
    check("stall_used", stall_armed, 1'b0);

    // Scoreboard full: results withheld
    hold_res = 1'b1;
    start_run(8);
    repeat (10) cycle();
    check("full_issued", issued, D);
    check("full_valid", op_valid, 1'b0);
    hold_res = 1'b0;
    wait_done(8, 100);

    // Mismatch injected on pair (1,0)
    corrupt_idx = 1;
    start_run(4);
    wait_done(4, 60);
    check("err_model", model_err, 1);
    corrupt_idx = -1;

    // Zero-length run
    start_run(0);
    check("num0_done", done, 1'b1);
    check("num0_busy", busy, 1'b0);
    repeat (3) cycle();
    check("num0_issued", issued, 0);

    // Full sweep with wrap-around, random operand readiness
    rnd_ready = 1'b1;
    start_run(256);
    wait_done(256, 3000);
    rnd_ready = 1'b0;

    // Reset mid-run
    start_run(20);
    repeat (6) cycle();
    check("midrun_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    res_valid = 1'b0; op_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("idle_after_abort");

    // Fresh run after abort
    start_run(6);
    wait_done(6, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
